dmem_arbiter: RTL

Sequencer and arbiter for the word-wide data memory. Shares the memory between the core load/store path and a word-only loader/debug port with round-robin arbitration. Performs byte and halfword loads with sign or zero extension. Because the memory writes only whole words, it implements SB/SH as a read-modify-write.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_lane_align.sv | 40 ++++
 rtl/dmem_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and funct3 encodings for the data-memory sequencer/arbiter.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_ACK} state_e;
    typedef enum logic {REQ_CORE, REQ_LOAD} req_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Unsigned byte/half encodings only exist for loads; every unknown code is a word.
    function automatic size_e access_size(input logic we, input logic [2:0] f3);
        if (f3 == F3_B || (!we && f3 == F3_BU)) return SZ_B;
        if (f3 == F3_H || (!we && f3 == F3_HU)) return SZ_H;
        return SZ_W;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, loader and memory signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  c_req;
    logic                  c_we;
    logic [2:0]            c_funct3;
    logic [DM_ADDRESS-1:0] c_addr;
    logic [DATA_W-1:0]     c_wdata;
    logic                  c_ack;
    logic [DATA_W-1:0]     c_rdata;
    logic                  c_err;
    logic                  l_req;
    logic                  l_we;
    logic [DM_ADDRESS-1:0] l_addr;
    logic [DATA_W-1:0]     l_wdata;
    logic                  l_ack;
    logic [DATA_W-1:0]     l_rdata;
    logic [DM_ADDRESS-1:0] mem_a;
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd;

    modport slave (
        input  c_req, c_we, c_funct3, c_addr, c_wdata,
        output c_ack, c_rdata, c_err,
        input  l_req, l_we, l_addr, l_wdata,
        output l_ack, l_rdata,
        output mem_a, mem_re, mem_we, mem_wd,
        input  mem_rd
    );

    modport master (
        output c_req, c_we, c_funct3, c_addr, c_wdata,
        input  c_ack, c_rdata, c_err,
        output l_req, l_we, l_addr, l_wdata,
        input  l_ack, l_rdata,
        input  mem_a, mem_re, mem_we, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte/halfword extraction with extension, and store-lane merge.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] mem_word,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merge_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_word[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'h0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'h0, half_v};
            default: load_data = mem_word;
        endcase

        merge_data = mem_word;
        case (funct3)
            F3_B: merge_data[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            F3_H: begin
                if (addr_lo[1]) merge_data[31:16] = store_data[15:0];
                else            merge_data[15:0]  = store_data[15:0];
            end
            default: merge_data = store_data;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin core/loader arbiter and word-memory sequencer with sub-word RMW.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned core accesses complete with c_err and no access.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [DM_ADDRESS-1:0] WORD_MASK = {{(DM_ADDRESS-2){1'b1}}, 2'b00};

    state_e state_q, state_d;
    req_e   ptr_q, ptr_d, id_q, id_d, win_id;
    size_e  win_size;
    logic   we_q, we_d, win_we, err_q, err_d, win_misalign;
    logic [2:0]            f3_q, f3_d, win_f3;
    logic [DM_ADDRESS-1:0] addr_q, addr_d, win_addr;
    logic [DATA_W-1:0]     wdata_q, wdata_d, win_wdata, rdata_q, rdata_d;
    logic [DATA_W-1:0]     load_data, merge_data;

    logic                  mem_re, mem_we, c_ack, l_ack, c_err;
    logic [DM_ADDRESS-1:0] mem_a;
    logic [DATA_W-1:0]     mem_wd, c_rdata, l_rdata;

    // ptr_q names the requester that wins a tie
    always_comb begin
        if (bus.c_req && (!bus.l_req || ptr_q == REQ_CORE)) begin
            win_id    = REQ_CORE;
            win_we    = bus.c_we;
            win_f3    = bus.c_funct3;
            win_addr  = bus.c_addr;
            win_wdata = bus.c_wdata;
        end else begin
            win_id    = REQ_LOAD;
            win_we    = bus.l_we;
            win_f3    = F3_W;
            win_addr  = bus.l_addr & WORD_MASK;
            win_wdata = bus.l_wdata;
        end
        win_size = access_size(win_we, win_f3);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign win_misalign = (win_id == REQ_CORE) &&
                          ((win_size == SZ_H && win_addr[0]) ||
                           (win_size == SZ_W && win_addr[1:0] != 2'b00));
`else
    assign win_misalign = 1'b0;
`endif

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .mem_word   (bus.mem_rd),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_wd  = '0;
        c_ack   = 1'b0;
        l_ack   = 1'b0;
        c_rdata = '0;
        l_rdata = '0;
        c_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    id_d    = win_id;
                    we_d    = win_we;
                    f3_d    = win_f3;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    rdata_d = '0;
                    ptr_d   = (win_id == REQ_CORE) ? REQ_LOAD : REQ_CORE;
                    if (win_misalign) begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end else if (win_we && win_size == SZ_W) begin
                        mem_we  = 1'b1;
                        mem_a   = win_addr & WORD_MASK;
                        mem_wd  = win_wdata;
                        state_d = ST_ACK;
                    end else begin
                        mem_re  = 1'b1;
                        mem_a   = win_addr & WORD_MASK;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // Stores only reach RD for SB/SH, so this is always the merge write
                if (we_q) begin
                    mem_we = 1'b1;
                    mem_a  = addr_q & WORD_MASK;
                    mem_wd = merge_data;
                end else begin
                    rdata_d = load_data;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (id_q == REQ_CORE) begin
                    c_ack   = 1'b1;
                    c_rdata = rdata_q;
                    c_err   = err_q;
                end else begin
                    l_ack   = 1'b1;
                    l_rdata = rdata_q;
                end
                id_d    = REQ_CORE;
                we_d    = 1'b0;
                f3_d    = '0;
                addr_d  = '0;
                wdata_d = '0;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes and acks are combinational, so a reset cycle must mask them
        if (reset) begin
            mem_re  = 1'b0;
            mem_we  = 1'b0;
            mem_a   = '0;
            mem_wd  = '0;
            c_ack   = 1'b0;
            l_ack   = 1'b0;
            c_rdata = '0;
            l_rdata = '0;
            c_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= REQ_CORE;
            id_q    <= REQ_CORE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_re  = mem_re;
    assign bus.mem_we  = mem_we;
    assign bus.mem_a   = mem_a;
    assign bus.mem_wd  = mem_wd;
    assign bus.c_ack   = c_ack;
    assign bus.l_ack   = l_ack;
    assign bus.c_rdata = c_rdata;
    assign bus.l_rdata = l_rdata;
    assign bus.c_err   = c_err;

endmodule
